// File: rtl/rf_pkg.sv
// Shared definitions for the register-file writeback path: default widths,
// requester identifiers and the write request record.
package rf_pkg;

   localparam int W_DEFAULT = 8;
   localparam int D_DEFAULT = 3;

   localparam logic REQ_LOAD = 1'b0;
   localparam logic REQ_ALU  = 1'b1;

   typedef struct packed {
      logic [D_DEFAULT-1:0] addr;
      logic [W_DEFAULT-1:0] data;
   } wr_req_t;

endpackage

// File: rtl/wb_slot.sv
// One-entry writeback holding slot: captures a request on a valid/ready
// handshake and releases it when the arbiter grants it.
module wb_slot #(
   parameter int W = 8,
   parameter int D = 3
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         valid_i,
   input  logic [D-1:0] addr_i,
   input  logic [W-1:0] data_i,
   input  logic         grant_i,
   output logic         ready_o,
   output logic         accept_o,
   output logic         full_o,
   output logic [D-1:0] addr_o,
   output logic [W-1:0] data_o
);

   logic         full_q, full_d;
   logic [D-1:0] addr_q, addr_d;
   logic [W-1:0] data_q, data_d;

   // A slot being drained this cycle can take a new entry on the same edge.
   assign ready_o  = !full_q || grant_i;
   assign accept_o = valid_i && ready_o;

   always_comb begin
      full_d = full_q;
      addr_d = addr_q;
      data_d = data_q;
      if (accept_o) begin
         full_d = 1'b1;
         addr_d = addr_i;
         data_d = data_i;
      end else if (grant_i) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         full_q <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         addr_q <= addr_d;
         data_q <= data_d;
      end
   end

   assign full_o = full_q;
   assign addr_o = addr_q;
   assign data_o = data_q;

endmodule

// File: rtl/reg_write_arbiter.sv
// Shares the register file write port between the load-return and ALU
// writeback requesters, draining their slots oldest first.
module reg_write_arbiter
   import rf_pkg::*;
#(
   parameter int W = W_DEFAULT,
   parameter int D = D_DEFAULT
) (
   input  logic         CLK,
   input  logic         Reset_n,
   input  logic         Req0_valid,
   output logic         Req0_ready,
   input  logic [D-1:0] Req0_addr,
   input  logic [W-1:0] Req0_data,
   input  logic         Req1_valid,
   output logic         Req1_ready,
   input  logic [D-1:0] Req1_addr,
   input  logic [W-1:0] Req1_data,
   output logic         Reg_write_en,
   output logic [D-1:0] Reg_write_address,
   output logic [W-1:0] Reg_write_data,
   input  logic [D-1:0] Rd_addr_0,
   input  logic [D-1:0] Rd_addr_1,
   output logic         Hazard_0,
   output logic         Hazard_1,
   output logic         Grant_id,
   output logic         Idle
);

   logic         full0, full1, acc0, acc1, gnt0, gnt1, gid, granted;
   logic [D-1:0] addr0, addr1;
   logic [W-1:0] data0, data1;

   // age_q: 1 when slot 1 holds the older entry; same_q: both captured together
   logic age_q, age_d, same_q, same_d, ptr_q, ptr_d;

   wb_slot #(.W(W), .D(D)) u_slot0 (
      .clk_i(CLK), .rst_n_i(Reset_n), .valid_i(Req0_valid), .addr_i(Req0_addr),
      .data_i(Req0_data), .grant_i(gnt0), .ready_o(Req0_ready), .accept_o(acc0),
      .full_o(full0), .addr_o(addr0), .data_o(data0)
   );

   wb_slot #(.W(W), .D(D)) u_slot1 (
      .clk_i(CLK), .rst_n_i(Reset_n), .valid_i(Req1_valid), .addr_i(Req1_addr),
      .data_i(Req1_data), .grant_i(gnt1), .ready_o(Req1_ready), .accept_o(acc1),
      .full_o(full1), .addr_o(addr1), .data_o(data1)
   );

   always_comb begin
      if (full0 && full1) gid = same_q ? ptr_q : age_q;
      else                gid = full1 ? REQ_ALU : REQ_LOAD;
      gnt0    = full0 && (gid == REQ_LOAD);
      gnt1    = full1 && (gid == REQ_ALU);
      granted = full0 || full1;
   end

   always_comb begin
      age_d  = age_q;
      same_d = same_q;
      ptr_d  = ptr_q;
      if (full0 && full1 && same_q) ptr_d = ~ptr_q;
      // A lone capture is newer than whatever the other slot may still hold.
      if (acc0 && acc1) begin
         same_d = 1'b1;
      end else if (acc0) begin
         same_d = 1'b0;
         age_d  = 1'b1;
      end else if (acc1) begin
         same_d = 1'b0;
         age_d  = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (!Reset_n) begin
         age_q  <= 1'b0;
         same_q <= 1'b0;
         ptr_q  <= 1'b0;
      end else begin
         age_q  <= age_d;
         same_q <= same_d;
         ptr_q  <= ptr_d;
      end
   end

   always_comb begin
      Reg_write_address = '0;
      Reg_write_data    = '0;
      if (gnt1) begin
         Reg_write_address = addr1;
         Reg_write_data    = data1;
      end else if (gnt0) begin
         Reg_write_address = addr0;
         Reg_write_data    = data0;
      end
   end

   // Entries being discarded by reset must never reach the register file.
   assign Reg_write_en = Reset_n && granted && (Reg_write_address != '0);
   assign Grant_id     = granted ? gid : 1'b0;
   assign Idle         = !full0 && !full1;

   logic [D-1:0] rd_addr [2];
   logic [1:0]   hazard;

   assign rd_addr[0] = Rd_addr_0;
   assign rd_addr[1] = Rd_addr_1;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_hazard
         assign hazard[gi] = (rd_addr[gi] != '0) &&
                             ((full0 && (addr0 == rd_addr[gi])) ||
                              (full1 && (addr1 == rd_addr[gi])));
      end
   endgenerate

   assign Hazard_0 = hazard[0];
   assign Hazard_1 = hazard[1];

endmodule
